fatorial_controlador: RTL and testbench

- Sequencing controller for the 8-bit factorial datapath. It computes resultado = n! using an iterative shift-add multiplier: an accumulator, a down-counter and a partial-product register, all owned by this block.
- It drives the 2-bit phase select that steers the shared operand Mux4 instances.
- It uses a start/done handshake toward the top-level test harness or host.

---
 rtl/fatorial_controlador.sv | 134 +++++++++++++
 tb/tb_fatorial_controlador.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fatorial_controlador.sv
// Sequencing controller for the 8-bit factorial datapath: computes n! mod 2^RES_W
// with an iterative shift-add multiplier and a start/done handshake.
//
// state  | meaning
// OCIOSO | idle, waiting for start
// CARGA  | initialise acc/prod/bit index, skip straight to FIM for n <= 1
// MULT   | one shift-add step per cycle over the N_W bits of cnt
// DECR   | fold product into acc, flag overflow, decrement cnt
// FIM    | present resultado with a one-cycle done pulse
module fatorial_controlador #(
  parameter int N_W   = 8,
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] resultado,
  output logic             overflow,
  output logic [1:0]       sel_operando
);

  localparam int BIT_W  = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int PROD_W = RES_W + N_W;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    CARGA  = 3'd1,
    MULT   = 3'd2,
    DECR   = 3'd3,
    FIM    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [RES_W-1:0]  acc, acc_nxt;
  logic [RES_W-1:0]  res_q, res_nxt;
  logic [N_W-1:0]    cnt, cnt_nxt, cnt_dec;
  logic [PROD_W-1:0] prod, prod_nxt, addend;
  logic [BIT_W-1:0]  bit_idx, bit_nxt;
  logic              ovf_q, ovf_nxt;
  logic [1:0]        sel_q, sel_nxt;

  assign cnt_dec = cnt - N_W'(1);
  assign addend  = {{N_W{1'b0}}, acc} << bit_idx;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    res_nxt   = res_q;
    cnt_nxt   = cnt;
    prod_nxt  = prod;
    bit_nxt   = bit_idx;
    ovf_nxt   = ovf_q;
    sel_nxt   = 2'd0;

    case (state)
      OCIOSO: begin
        if (start) begin
          cnt_nxt   = n;
          ovf_nxt   = 1'b0;
          state_nxt = CARGA;
        end
      end
      CARGA: begin
        acc_nxt  = RES_W'(1);
        prod_nxt = '0;
        bit_nxt  = '0;
        if (cnt <= N_W'(1)) state_nxt = FIM;
        else                state_nxt = MULT;
      end
      MULT: begin
        if (cnt[bit_idx]) prod_nxt = prod + addend;
        if (bit_idx == BIT_W'(N_W - 1)) state_nxt = DECR;
        else                            bit_nxt   = bit_idx + BIT_W'(1);
      end
      DECR: begin
        acc_nxt  = prod[RES_W-1:0];
        if (|prod[PROD_W-1:RES_W]) ovf_nxt = 1'b1;
        cnt_nxt  = cnt_dec;
        prod_nxt = '0;
        bit_nxt  = '0;
        if (cnt_dec <= N_W'(1)) state_nxt = FIM;
        else                    state_nxt = MULT;
      end
      FIM: begin
        state_nxt = OCIOSO;
      end
      default: begin
        state_nxt = OCIOSO;
      end
    endcase

    // resultado is captured on entry to FIM so it is already valid while done is high
    if (state_nxt == FIM) res_nxt = acc_nxt;

    case (state_nxt)
      MULT:    sel_nxt = 2'd1;
      DECR:    sel_nxt = 2'd2;
      FIM:     sel_nxt = 2'd3;
      default: sel_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OCIOSO;
      acc     <= RES_W'(1);
      res_q   <= '0;
      cnt     <= '0;
      prod    <= '0;
      bit_idx <= '0;
      ovf_q   <= 1'b0;
      sel_q   <= 2'd0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      res_q   <= res_nxt;
      cnt     <= cnt_nxt;
      prod    <= prod_nxt;
      bit_idx <= bit_nxt;
      ovf_q   <= ovf_nxt;
      sel_q   <= sel_nxt;
    end
  end

  assign busy         = (state != OCIOSO) && (state != FIM);
  assign done         = (state == FIM);
  assign resultado    = res_q;
  assign overflow     = ovf_q;
  assign sel_operando = sel_q;

endmodule

// File: tb/tb_fatorial_controlador.sv
// Self-checking bench for fatorial_controlador: directed scenarios plus random
// operands compared against an arithmetic factorial/latency model.
module tb_fatorial_controlador;
  localparam int N_W   = 8;
  localparam int RES_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N_W-1:0]   n = '0;
  logic             busy, done, overflow;
  logic [RES_W-1:0] resultado;
  logic [1:0]       sel_operando;

  int checks = 0;
  int errors = 0;
  int sel_log[$];

  always #5 clk = ~clk;

  fatorial_controlador #(.N_W(N_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n),
    .busy(busy), .done(done), .resultado(resultado),
    .overflow(overflow), .sel_operando(sel_operando)
  );

  always @(negedge clk) begin
    checks++;
    if (busy && done) begin
      errors++;
      $display("FAIL busy_done_exclusive: busy=%0b done=%0b required not both high", busy, done);
    end
  end

  function automatic void model(input int v, output logic [15:0] r, output logic o);
    longint p = 1;
    o = 1'b0;
    for (int i = 2; i <= v; i++) begin
      p = p * i;
      if (p >= 65536) o = 1'b1;
      p = p % 65536;
    end
    r = 16'(p);
  endfunction

  function automatic int model_latency(input int v);
    return (v <= 1) ? 2 : 2 + (v - 1) * (N_W + 1);
  endfunction

  // Launch one run; measure latency (edges from accept to the edge that sees done)
  task automatic run_op(input int v, output logic [15:0] r, output logic o,
                        output int lat, output int bcnt);
    int k;
    @(negedge clk);
    start = 1'b1;
    n = N_W'(v);
    @(posedge clk);
    k = 0;
    bcnt = 0;
    lat = -1;
    r = 'x;
    o = 'x;
    sel_log.delete();
    while (k < 3000) begin
      @(negedge clk);
      start = 1'b0;
      n = N_W'($urandom);
      sel_log.push_back(int'(sel_operando));
      if (done) begin
        lat = k + 1;
        r = resultado;
        o = overflow;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk);
      k++;
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL run_timeout: n=%0d no done within %0d edges", v, k);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, overflow, sel_operando, resultado} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b ovf=%0b sel=%0d res=%0h required all 0",
               busy, done, overflow, sel_operando, resultado);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_small();
    logic [15:0] r; logic o; int lat, bc;
    for (int v = 0; v <= 1; v++) begin
      run_op(v, r, o, lat, bc);
      checks++;
      if (lat !== 2 || r !== 16'd1 || o !== 1'b0) begin
        errors++;
        $display("FAIL small_n: n=%0d lat=%0d res=%0d ovf=%0b required lat=2 res=1 ovf=0", v, lat, r, o);
      end
    end
  endtask

  task automatic test_n5();
    logic [15:0] r; logic o; int lat, bc;
    int exp_sel[$];
    run_op(5, r, o, lat, bc);
    checks++;
    if (lat !== 38 || bc !== 37 || r !== 16'h0078 || o !== 1'b0) begin
      errors++;
      $display("FAIL n5_run: lat=%0d busy=%0d res=%0h ovf=%0b required 38 37 0078 0", lat, bc, r, o);
    end
    exp_sel.push_back(0);
    for (int it = 0; it < 4; it++) begin
      for (int b = 0; b < N_W; b++) exp_sel.push_back(1);
      exp_sel.push_back(2);
    end
    exp_sel.push_back(3);
    checks++;
    if (sel_log.size() != exp_sel.size()) begin
      errors++;
      $display("FAIL n5_sel_len: got %0d required %0d", sel_log.size(), exp_sel.size());
    end else begin
      for (int i = 0; i < exp_sel.size(); i++) begin
        checks++;
        if (sel_log[i] != exp_sel[i]) begin
          errors++;
          $display("FAIL n5_sel[%0d]: got %0d required %0d", i, sel_log[i], exp_sel[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] r; logic o; int lat, bc;
    int vals[3] = '{8, 9, 3};
    logic [15:0] er[3] = '{16'h9D80, 16'h8980, 16'd6};
    logic eo[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(vals[i], r, o, lat, bc);
      checks++;
      if (r !== er[i] || o !== eo[i]) begin
        errors++;
        $display("FAIL overflow_seq: n=%0d res=%0h ovf=%0b required %0h %0b",
                 vals[i], r, o, er[i], eo[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    logic [15:0] r = '0;
    @(negedge clk);
    start = 1'b1; n = 8'd4;
    @(negedge clk);
    start = 1'b0; n = 8'd0;
    repeat (3) @(negedge clk);
    start = 1'b1; n = 8'd7;
    @(negedge clk);
    start = 1'b0; n = 8'd0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        r = resultado;
      end
    end
    checks++;
    if (dones != 1 || r !== 16'd24 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: dones=%0d res=%0d busy=%0b required 1 24 0", dones, r, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] r; logic o; int lat, bc;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; n = 8'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sel_operando !== 2'd1) begin
      errors++;
      $display("FAIL mid_reset_in_mult: sel=%0d required 1", sel_operando);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overflow, sel_operando, resultado} !== 21'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%0b done=%0b ovf=%0b sel=%0d res=%0h required all 0",
               busy, done, overflow, sel_operando, resultado);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: dones=%0d required 0", dones);
    end
    run_op(6, r, o, lat, bc);
    checks++;
    if (r !== 16'd720 || o !== 1'b0 || lat !== model_latency(6)) begin
      errors++;
      $display("FAIL mid_reset_rerun: res=%0d ovf=%0b lat=%0d required 720 0 %0d",
               r, o, lat, model_latency(6));
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int low_run = 0;
    int gaps[$];
    int c = 0;
    @(negedge clk);
    start = 1'b1; n = 8'd3;
    while (pulses < 3 && c < 300) begin
      @(negedge clk);
      c++;
      if (done) begin
        if (pulses > 0) gaps.push_back(low_run);
        pulses++;
        low_run = 0;
        checks++;
        if (resultado !== 16'd6) begin
          errors++;
          $display("FAIL b2b_result: pulse=%0d res=%0d required 6", pulses, resultado);
        end
      end else begin
        low_run++;
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d required 3", pulses);
    end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] != 20) begin
        errors++;
        $display("FAIL b2b_spacing: gap %0d = %0d cycles without done, required 20", i, gaps[i]);
      end
    end
    for (int w = 0; w < 60 && (busy || done); w++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] r, er; logic o, eo; int lat, bc, v;
    for (int i = 0; i < 12; i++) begin
      v = (i < 2) ? 255 - i : int'($urandom_range(0, 30));
      model(v, er, eo);
      run_op(v, r, o, lat, bc);
      checks++;
      if (r !== er || o !== eo || lat !== model_latency(v)) begin
        errors++;
        $display("FAIL random_run: n=%0d res=%0h ovf=%0b lat=%0d required %0h %0b %0d",
                 v, r, o, lat, er, eo, model_latency(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_n5();
    test_overflow();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
